error_counter_bank: RTL and testbench
=====================================

ERROR_COUNTER_BANK -- requirements
Module: error_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 9, number of error channels (1-32).
REQ-002 SHALL have parameter CNT_W, default 32, per-channel counter width (8-32).
REQ-003 SHALL have parameter WIN_OPS, default 1000, operations per error-rate window (2-65535).
REQ-004 SHALL have parameter RATE_W, default 8, error_rate width.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with ports as follows.
- clk  in  1  sole clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- err_strobe  in  NUM_CH  one-cycle error pulse per channel; bit i is channel i.
- op_done  in  1  one-cycle pulse per completed read/write operation.
- clear_all  in  1  clears all counters, window and rate state.
- clear_mask  in  NUM_CH  clears the selected channels.
- snap_req  in  1  captures all live counters.
- alarm_thresh  in  RATE_W  alarm threshold; 0 disables the alarm.
- alarm_ack  in  1  clears the sticky alarm.
- cnt_flat  out  NUM_CH*CNT_W  live counters; channel i at [i*CNT_W +: CNT_W].
- snap_flat  out  NUM_CH*CNT_W  snapshot counters, same packing.
- snap_valid  out  1  one-cycle pulse when the snapshot updates.
- total_errors  out  CNT_W+5  registered sum of live counters.
- any_error  out  1  total_errors != 0.
- error_rate  out  RATE_W  errors in the last completed window, saturated.
- rate_alarm  out  1  sticky alarm.

Function
REQ-006 Counters SHALL saturate: at all-ones, a strobe is ignored; there is no wrap.
REQ-007 A strobe in cycle N SHALL appear in cnt_flat after edge N+1.
REQ-008 Clear priority SHALL be: clear_all first, then clear_mask[i], then strobe.
REQ-009 With clear_mask[i] and err_strobe[i] in the same cycle, counter i SHALL load 1, so no event is lost.
REQ-010 With clear_all and a strobe in the same cycle, the result SHALL be 0.
REQ-011 snap_req in cycle N SHALL load snap_flat with cnt_flat as it was in cycle N, before that cycle's updates.
REQ-012 snap_valid SHALL be 1 in cycle N+1 only.
REQ-013 snap_req combined with clear_mask or clear_all SHALL form an atomic read-and-clear: the snapshot holds the pre-clear values.
REQ-014 clear_all and clear_mask SHALL NOT alter snap_flat.
REQ-015 total_errors SHALL be the unsaturated sum of live counters, registered, one cycle behind cnt_flat.
REQ-016 any_error SHALL be derived combinationally from total_errors.
REQ-017 The window op counter SHALL count op_done from 0 to WIN_OPS-1.
REQ-018 The window error accumulator (16 bits) SHALL add popcount(err_strobe) each cycle and saturate at 0xFFFF.
REQ-019 Window close SHALL be op_done while the op counter equals WIN_OPS-1; at close:
- error_rate <= min(accumulator including this cycle's popcount, 2^RATE_W-1);
- op counter <= 0;
- accumulator <= 0.
REQ-020 A strobe in the close cycle SHALL count toward the closing window only.
REQ-021 Strobes with no op_done SHALL still accumulate.
REQ-022 Channel saturation SHALL NOT affect the accumulator.
REQ-023 At window close, if alarm_thresh != 0 and the new error_rate >= alarm_thresh, rate_alarm SHALL set.
REQ-024 rate_alarm SHALL be sticky; alarm_ack clears it.
REQ-025 A set event SHALL win over a simultaneous alarm_ack.
REQ-026 clear_all SHALL zero the window counter, the accumulator, error_rate and rate_alarm.
REQ-027 clear_all SHALL NOT alter alarm_thresh handling.

Reset
REQ-028 While reset_n=0 (asynchronous), all counters, snap_flat, total_errors, the window counter, the accumulator and error_rate SHALL be 0, and snap_valid and rate_alarm SHALL be 0.
REQ-029 Reset asserted mid-window SHALL discard the partial window.
REQ-030 Deassertion SHALL be synchronised externally; the first active edge after release SHALL process inputs normally.

Verification
REQ-031 Bench SHALL drive 5 strobes on ch2 and then snap_req with clear_mask[2] and err_strobe[2] in the same cycle -> snap ch2=5, live ch2=1, snap_valid one cycle.
REQ-032 Bench SHALL run CNT_W=8 with 300 strobes on ch0 -> ch0=255 held, total_errors=255, accumulator=300 if no window closes.
REQ-033 Bench SHALL run WIN_OPS=4, RATE_W=8, 3 errors, then 4 op_done with a ch1 strobe on the 4th -> error_rate=4, next window starts at 0.
REQ-034 Bench SHALL run alarm_thresh=3 with a window closing at rate 4 and alarm_ack on the same edge -> rate_alarm=1; ack next cycle -> 0.
REQ-035 Bench SHALL apply clear_all together with strobes on all channels -> all counters 0, error_rate 0, rate_alarm 0, snapshot unchanged.
REQ-036 Bench SHALL assert reset_n=0 asynchronously mid-window with counters nonzero -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/error_counter_bank.sv
// Saturating per-channel error counters with atomic snapshot, running total and windowed error-rate alarm.
// Latency: counters/snapshot/rate 1 cycle, total_errors 2 cycles after a strobe; no backpressure, every pulse is accepted.
module error_counter_bank #(
  parameter int NUM_CH  = 9,
  parameter int CNT_W   = 32,
  parameter int WIN_OPS = 1000,
  parameter int RATE_W  = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         err_strobe,
  input  logic                      op_done,
  input  logic                      clear_all,
  input  logic [NUM_CH-1:0]         clear_mask,
  input  logic                      snap_req,
  input  logic [RATE_W-1:0]         alarm_thresh,
  input  logic                      alarm_ack,
  output logic [NUM_CH*CNT_W-1:0]   cnt_flat,
  output logic [NUM_CH*CNT_W-1:0]   snap_flat,
  output logic                      snap_valid,
  output logic [CNT_W+4:0]          total_errors,
  output logic                      any_error,
  output logic [RATE_W-1:0]         error_rate,
  output logic                      rate_alarm
);

  localparam int OP_W  = $clog2(WIN_OPS);
  localparam int TOT_W = CNT_W + 5;
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(WIN_OPS - 1);
  // RATE_W is at most 16, since the rate is a clamp of the 16-bit accumulator.
  localparam logic [16:0] RATE_MAX = 17'((1 << RATE_W) - 1);

  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [CNT_W-1:0]  snap_q [NUM_CH];
  logic              snap_vld_q;
  logic [TOT_W-1:0]  total_q, total_d;
  logic [OP_W-1:0]   op_cnt_q, op_cnt_d;
  logic [15:0]       acc_q, acc_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              alarm_q, alarm_d;

  logic [5:0]        pop;
  logic [16:0]       acc_sum;
  logic [15:0]       acc_sat;
  logic [RATE_W-1:0] rate_new;
  logic              win_close;

  // A clear and a strobe on the same channel load 1 so the event is not lost.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clear_all) begin
        cnt_d[i] = '0;
      end else if (clear_mask[i]) begin
        cnt_d[i] = {{(CNT_W-1){1'b0}}, err_strobe[i]};
      end else if (err_strobe[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    total_d = '0;
    pop     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      total_d = total_d + {5'b0, cnt_q[i]};
      pop     = pop + {5'b0, err_strobe[i]};
    end
  end

  always_comb begin
    acc_sum   = {1'b0, acc_q} + {11'b0, pop};
    acc_sat   = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];
    rate_new  = ({1'b0, acc_sat} > RATE_MAX) ? {RATE_W{1'b1}} : acc_sat[RATE_W-1:0];
    win_close = op_done && (op_cnt_q == OP_LAST);
  end

  always_comb begin
    op_cnt_d = op_cnt_q;
    acc_d    = acc_sat;
    rate_d   = rate_q;
    alarm_d  = alarm_q;
    if (clear_all) begin
      op_cnt_d = '0;
      acc_d    = '0;
      rate_d   = '0;
      alarm_d  = 1'b0;
    end else begin
      if (win_close) begin
        op_cnt_d = '0;
        acc_d    = '0;
        rate_d   = rate_new;
      end else if (op_done) begin
        op_cnt_d = op_cnt_q + OP_W'(1);
      end
      // A set at window close wins over a simultaneous acknowledge.
      if (win_close && (alarm_thresh != '0) && (rate_new >= alarm_thresh)) begin
        alarm_d = 1'b1;
      end else if (alarm_ack) begin
        alarm_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      snap_vld_q <= 1'b0;
      total_q    <= '0;
      op_cnt_q   <= '0;
      acc_q      <= '0;
      rate_q     <= '0;
      alarm_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        if (snap_req) begin
          snap_q[i] <= cnt_q[i];
        end
      end
      snap_vld_q <= snap_req;
      total_q    <= total_d;
      op_cnt_q   <= op_cnt_d;
      acc_q      <= acc_d;
      rate_q     <= rate_d;
      alarm_q    <= alarm_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign cnt_flat[g*CNT_W +: CNT_W]  = cnt_q[g];
    assign snap_flat[g*CNT_W +: CNT_W] = snap_q[g];
  end

  assign snap_valid   = snap_vld_q;
  assign total_errors = total_q;
  assign any_error    = (total_q != '0);
  assign error_rate   = rate_q;
  assign rate_alarm   = alarm_q;

endmodule

// File: tb/tb_error_counter_bank.sv
// Directed bench for error_counter_bank: stimulus queues expected values, a negedge monitor compares them.
module tb_error_counter_bank;

  localparam int NUM_CH  = 9;
  localparam int CNT_W   = 8;
  localparam int WIN_OPS = 4;
  localparam int RATE_W  = 8;
  localparam int FW      = NUM_CH * CNT_W;

  localparam int S_CNT = 0, S_CNTALL = 1, S_SNAPALL = 2, S_TOTAL = 3, S_ANY = 4;
  localparam int S_RATE = 5, S_ALARM = 6, S_SVLD = 7, S_ACC = 8, S_OPC = 9;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NUM_CH-1:0] err_strobe;
  logic              op_done;
  logic              clear_all;
  logic [NUM_CH-1:0] clear_mask;
  logic              snap_req;
  logic [RATE_W-1:0] alarm_thresh;
  logic              alarm_ack;
  logic [FW-1:0]     cnt_flat;
  logic [FW-1:0]     snap_flat;
  logic              snap_valid;
  logic [CNT_W+4:0]  total_errors;
  logic              any_error;
  logic [RATE_W-1:0] error_rate;
  logic              rate_alarm;

  always #5 clk = ~clk;

  error_counter_bank #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_OPS(WIN_OPS), .RATE_W(RATE_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .err_strobe(err_strobe), .op_done(op_done),
    .clear_all(clear_all), .clear_mask(clear_mask), .snap_req(snap_req),
    .alarm_thresh(alarm_thresh), .alarm_ack(alarm_ack), .cnt_flat(cnt_flat),
    .snap_flat(snap_flat), .snap_valid(snap_valid), .total_errors(total_errors),
    .any_error(any_error), .error_rate(error_rate), .rate_alarm(rate_alarm)
  );

  typedef struct {
    int            cyc;
    int            sel;
    int            ch;
    logic [FW-1:0] val;
  } chk_t;

  chk_t          chk_q[$];
  logic [FW-1:0] snap_exp_q[$];
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  logic [FW-1:0] mon_act;
  logic [FW-1:0] mon_exp;
  logic [FW-1:0] vec;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] actual(int sel, int ch);
    case (sel)
      S_CNT:     return FW'(cnt_flat[ch*CNT_W +: CNT_W]);
      S_CNTALL:  return cnt_flat;
      S_SNAPALL: return snap_flat;
      S_TOTAL:   return FW'(total_errors);
      S_ANY:     return FW'(any_error);
      S_RATE:    return FW'(error_rate);
      S_ALARM:   return FW'(rate_alarm);
      S_SVLD:    return FW'(snap_valid);
      S_ACC:     return FW'(dut.acc_q);
      default:   return FW'(dut.op_cnt_q);
    endcase
  endfunction

  function automatic string sname(int sel);
    case (sel)
      S_CNT:     return "cnt";
      S_CNTALL:  return "cnt_flat";
      S_SNAPALL: return "snap_flat";
      S_TOTAL:   return "total_errors";
      S_ANY:     return "any_error";
      S_RATE:    return "error_rate";
      S_ALARM:   return "rate_alarm";
      S_SVLD:    return "snap_valid";
      S_ACC:     return "win_acc";
      default:   return "win_ops";
    endcase
  endfunction

  // Monitor: timed checks due this cycle, plus a snapshot compare on every snap_valid.
  always @(negedge clk) begin
    for (int k = chk_q.size() - 1; k >= 0; k--) begin
      if (chk_q[k].cyc == cyc) begin
        mon_act = actual(chk_q[k].sel, chk_q[k].ch);
        checks++;
        if (mon_act !== chk_q[k].val) begin
          errors++;
          $display("FAIL %s ch%0d cyc%0d: got %0h expected %0h",
                   sname(chk_q[k].sel), chk_q[k].ch, cyc, mon_act, chk_q[k].val);
        end
        chk_q.delete(k);
      end
    end
    if (snap_valid === 1'b1) begin
      checks++;
      if (snap_exp_q.size() == 0) begin
        errors++;
        $display("FAIL snap_pulse cyc%0d: got snap_valid=1 expected no snapshot", cyc);
      end else begin
        mon_exp = snap_exp_q.pop_front();
        if (snap_flat !== mon_exp) begin
          errors++;
          $display("FAIL snap_data cyc%0d: got %0h expected %0h", cyc, snap_flat, mon_exp);
        end
      end
    end
  end

  task automatic exp_chk(int dc, int sel, int ch, logic [FW-1:0] val);
    chk_t c;
    c.cyc = cyc + dc;
    c.sel = sel;
    c.ch  = ch;
    c.val = val;
    chk_q.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    err_strobe = '0;
    op_done    = 1'b0;
    clear_all  = 1'b0;
    clear_mask = '0;
    snap_req   = 1'b0;
    alarm_ack  = 1'b0;
  endtask

  task automatic exp_all_zero();
    exp_chk(0, S_CNTALL, 0, '0);
    exp_chk(0, S_SNAPALL, 0, '0);
    exp_chk(0, S_TOTAL, 0, '0);
    exp_chk(0, S_ANY, 0, '0);
    exp_chk(0, S_RATE, 0, '0);
    exp_chk(0, S_ALARM, 0, '0);
    exp_chk(0, S_SVLD, 0, '0);
    exp_chk(0, S_ACC, 0, '0);
    exp_chk(0, S_OPC, 0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; err_strobe = '0; op_done = 1'b0; clear_all = 1'b0;
    clear_mask = '0; snap_req = 1'b0; alarm_thresh = '0; alarm_ack = 1'b0;
    step();
    step();
    exp_all_zero();
    reset_n = 1'b1;

    // Five strobes on ch2, then atomic snapshot + clear with a coincident strobe.
    repeat (5) begin err_strobe[2] = 1'b1; step(); end
    exp_chk(0, S_CNT, 2, FW'(5));
    exp_chk(0, S_TOTAL, 0, FW'(4));
    snap_req = 1'b1; clear_mask[2] = 1'b1; err_strobe[2] = 1'b1;
    snap_exp_q.push_back(FW'(5) << (2*CNT_W));
    step();
    exp_chk(0, S_CNT, 2, FW'(1));
    exp_chk(0, S_SVLD, 0, FW'(1));
    exp_chk(1, S_SVLD, 0, FW'(0));
    exp_chk(0, S_TOTAL, 0, FW'(5));
    exp_chk(1, S_TOTAL, 0, FW'(1));
    exp_chk(0, S_ANY, 0, FW'(1));
    exp_chk(0, S_ACC, 0, FW'(6));

    clear_all = 1'b1;
    step();
    exp_chk(0, S_CNTALL, 0, '0);
    exp_chk(0, S_ACC, 0, '0);
    exp_chk(0, S_SNAPALL, 0, FW'(5) << (2*CNT_W));
    exp_chk(1, S_TOTAL, 0, '0);

    // Window: 3 errors, then 4 op_done with a ch1 strobe and an ack on the closing one.
    alarm_thresh = 8'd3;
    repeat (3) begin err_strobe[0] = 1'b1; step(); end
    exp_chk(0, S_ACC, 0, FW'(3));
    repeat (3) begin op_done = 1'b1; step(); end
    exp_chk(0, S_OPC, 0, FW'(3));
    exp_chk(0, S_RATE, 0, '0);
    op_done = 1'b1; err_strobe[1] = 1'b1; alarm_ack = 1'b1;
    step();
    exp_chk(0, S_RATE, 0, FW'(4));
    exp_chk(0, S_ALARM, 0, FW'(1));
    exp_chk(0, S_ACC, 0, '0);
    exp_chk(0, S_OPC, 0, '0);
    exp_chk(0, S_CNT, 1, FW'(1));
    alarm_ack = 1'b1;
    step();
    exp_chk(0, S_ALARM, 0, '0);
    exp_chk(0, S_RATE, 0, FW'(4));
    repeat (4) begin op_done = 1'b1; step(); end
    exp_chk(0, S_RATE, 0, '0);
    exp_chk(0, S_ALARM, 0, '0);

    // Threshold 0 disables the alarm even for a 9-error window.
    alarm_thresh = '0;
    err_strobe = '1; op_done = 1'b1;
    step();
    repeat (3) begin op_done = 1'b1; step(); end
    exp_chk(0, S_RATE, 0, FW'(9));
    exp_chk(0, S_ALARM, 0, '0);

    // Rate equal to threshold sets the alarm.
    alarm_thresh = 8'd9;
    err_strobe = '1; op_done = 1'b1;
    step();
    repeat (3) begin op_done = 1'b1; step(); end
    exp_chk(0, S_RATE, 0, FW'(9));
    exp_chk(0, S_ALARM, 0, FW'(1));
    vec = '0;
    for (int i = 0; i < NUM_CH; i++) vec[i*CNT_W +: CNT_W] = 8'd2;
    vec[0 +: CNT_W] = 8'd5;
    vec[CNT_W +: CNT_W] = 8'd3;
    exp_chk(0, S_CNTALL, 0, vec);

    // clear_all with strobes on every channel.
    clear_all = 1'b1; err_strobe = '1;
    step();
    exp_chk(0, S_CNTALL, 0, '0);
    exp_chk(0, S_RATE, 0, '0);
    exp_chk(0, S_ALARM, 0, '0);
    exp_chk(0, S_ACC, 0, '0);
    exp_chk(0, S_SNAPALL, 0, FW'(5) << (2*CNT_W));
    exp_chk(0, S_SVLD, 0, '0);

    // 300 strobes on ch0: counter saturates, accumulator does not.
    for (int i = 0; i < 300; i++) begin
      err_strobe[0] = 1'b1;
      step();
      if (i == 254 || i == 255) exp_chk(0, S_CNT, 0, FW'(255));
    end
    exp_chk(0, S_CNTALL, 0, FW'(255));
    exp_chk(0, S_ACC, 0, FW'(300));
    exp_chk(1, S_TOTAL, 0, FW'(255));
    repeat (4) begin op_done = 1'b1; step(); end
    exp_chk(0, S_RATE, 0, FW'(255));
    exp_chk(0, S_ALARM, 0, FW'(1));

    // Partial window, then asynchronous reset between clock edges.
    op_done = 1'b1; err_strobe[5] = 1'b1;
    step();
    op_done = 1'b1;
    step();
    snap_req = 1'b1;
    step();
    reset_n = 1'b0;
    exp_all_zero();
    step();
    reset_n = 1'b1;
    err_strobe[0] = 1'b1; op_done = 1'b1;
    step();
    exp_chk(0, S_CNT, 0, FW'(1));
    exp_chk(0, S_OPC, 0, FW'(1));
    op_done = 1'b1;
    step();
    exp_chk(0, S_RATE, 0, '0);
    repeat (2) begin op_done = 1'b1; step(); end
    exp_chk(0, S_RATE, 0, FW'(1));
    exp_chk(0, S_ALARM, 0, '0);

    repeat (3) step();
    checks++;
    if (chk_q.size() != 0 || snap_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got %0d checks and %0d snapshots pending expected 0",
               chk_q.size(), snap_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
